bsr_chain: RTL

- 10-cell boundary scan register (BSR) placed between the device pins and `core_logic`.
- Captures the pin inputs and the core outputs, and shifts serially between TDI and TDO.
- Latches an update register, and muxes either the functional path or the update register onto the core inputs (INTEST) and onto the pins (EXTEST).
- Sequenced by the TAP controller's capture_dr/shift_dr/update_dr strobes on the single system clock.

---
 rtl/bsr_chain_if.sv | 28 ++
 rtl/bsr_chain.sv | 73 +++++++
 2 files changed

// File: rtl/bsr_chain_if.sv
// TAP-side scan interface for the boundary scan register: serial data plus
// the capture/shift/update strobes and the instruction-derived mode.
interface bsr_chain_if;
    logic       tdi;
    logic       tdo;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [1:0] mode;

    modport master (
        output tdi,
        output capture_dr,
        output shift_dr,
        output update_dr,
        output mode,
        input  tdo
    );

    modport slave (
        input  tdi,
        input  capture_dr,
        input  shift_dr,
        input  update_dr,
        input  mode,
        output tdo
    );
endinterface

// File: rtl/bsr_chain.sv
// Boundary scan register sitting between the device pins and core_logic:
// captures pins/core outputs, scans serially, and can override either side.
module bsr_chain #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    bsr_chain_if.slave        tap,
    input  logic [IN_W-1:0]   pin_in,
    output logic [IN_W-1:0]   core_x,
    input  logic [OUT_W-1:0]  core_y,
    output logic [OUT_W-1:0]  pin_out,
    output logic              pin_oe
);

    localparam int L = IN_W + OUT_W + 1;

    typedef enum logic [1:0] {
        MODE_FUNCTIONAL = 2'b00,
        MODE_EXTEST     = 2'b01,
        MODE_INTEST     = 2'b10,
        MODE_SAMPLE     = 2'b11
    } mode_e;

    mode_e        mode_sel;
    logic         test_drive;
    logic [L-1:0] sr_q, sr_d;
    logic [L-1:0] ur_q, ur_d;

    assign mode_sel   = mode_e'(tap.mode);
    assign test_drive = (mode_sel == MODE_EXTEST) || (mode_sel == MODE_INTEST);

    // Only one strobe acts per edge: capture beats shift, shift beats update.
    always_comb begin
        sr_d = sr_q;
        ur_d = ur_q;
        if (tap.capture_dr) begin
            sr_d = {pin_oe, core_y, pin_in};
        end else if (tap.shift_dr) begin
            sr_d = {tap.tdi, sr_q[L-1:1]};
        end else if (tap.update_dr) begin
            ur_d = sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
            ur_q <= '0;
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    assign tap.tdo = sr_q[0];

    // pin_oe is driven from ur, never from sr, so capturing it forms no loop.
    always_comb begin
        core_x  = pin_in;
        pin_out = core_y;
        pin_oe  = 1'b1;
        if (mode_sel == MODE_INTEST) begin
            core_x = ur_q[IN_W-1:0];
        end
        if (test_drive) begin
            pin_out = ur_q[IN_W+OUT_W-1:IN_W];
            pin_oe  = ur_q[L-1];
        end
    end

endmodule
